// File: rtl/gpio_button_conditioner.sv
// Multi-channel pad button conditioner: synchroniser, polarity normalisation,
// tick-based debounce, press/release strobes and per-channel auto-repeat.
module gpio_button_conditioner #(
    parameter int unsigned         CHANNELS     = 5,
    parameter int unsigned         SYNC_STAGES  = 2,
    parameter int unsigned         TICK_DIV     = 250,
    parameter int unsigned         STABLE_TICKS = 4,
    parameter int unsigned         ACTIVE_LOW   = 1,
    parameter logic [CHANNELS-1:0] REPEAT_MASK  = CHANNELS'(5'b11000),
    parameter int unsigned         REPEAT_DELAY = 60,
    parameter int unsigned         REPEAT_RATE  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                tick
);

    localparam int unsigned TW   = $clog2(TICK_DIV);
    localparam int unsigned CW   = 4;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0]       STABLE_C  = CW'(STABLE_TICKS);
    localparam logic [RW-1:0]       DELAY_C   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0]       RATE_C    = RW'(REPEAT_RATE);
    localparam logic [CHANNELS-1:0] REL_LVL   = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] raw;
    logic [TW-1:0]       tcnt;
    logic [TW-1:0]       tcnt_nxt;

    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [RW-1:0]       rep_q   [CHANNELS];
    logic [RW-1:0]       rep_d   [CHANNELS];
    logic [RW-1:0]       rep_nxt [CHANNELS];
    logic [CHANNELS-1:0] phase_q;
    logic [CHANNELS-1:0] phase_d;
    logic [CHANNELS-1:0] rep_ph;
    logic [CHANNELS-1:0] rep_fire;
    logic [CHANNELS-1:0] pressed_d;
    logic [CHANNELS-1:0] press_d;
    logic [CHANNELS-1:0] release_d;

    // Pad synchroniser, free-running regardless of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= REL_LVL;
        end else begin
            sync_q[0] <= btn_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign raw = sync_q[SYNC_STAGES-1] ^ REL_LVL;

    // Sample tick; registered so it is high while the counter sits at TICK_DIV-1
    assign tcnt_nxt = (tcnt == TICK_LAST) ? '0 : tcnt + TW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tcnt <= tcnt_nxt;
            tick <= (tcnt_nxt == TICK_LAST);
        end
    end

    // Candidate repeat-counter step per channel; applied only when held on a tick
    always_comb begin
        rep_fire = '0;
        rep_ph   = phase_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            rep_nxt[i] = rep_q[i] + RW'(1);
            if (!phase_q[i] && rep_nxt[i] == DELAY_C) begin
                rep_fire[i] = 1'b1;
                rep_nxt[i]  = '0;
                rep_ph[i]   = 1'b1;
            end else if (phase_q[i] && rep_nxt[i] == RATE_C) begin
                rep_fire[i] = 1'b1;
                rep_nxt[i]  = '0;
            end
        end
    end

    // Debounce acceptance and repeat scheduling
    always_comb begin
        pressed_d = pressed;
        press_d   = '0;
        release_d = '0;
        phase_d   = phase_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_d[i] = cnt_q[i];
            rep_d[i] = rep_q[i];
        end
        if (!enable) begin
            pressed_d = '0;
            phase_d   = '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_d[i] = '0;
                rep_d[i] = '0;
            end
        end else if (tick) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (raw[i] != pressed[i] && cnt_q[i] + CW'(1) == STABLE_C) begin
                    cnt_d[i]     = '0;
                    pressed_d[i] = raw[i];
                    press_d[i]   = raw[i];
                    release_d[i] = ~raw[i];
                    rep_d[i]     = '0;
                    phase_d[i]   = 1'b0;
                end else begin
                    cnt_d[i] = (raw[i] == pressed[i]) ? '0 : cnt_q[i] + CW'(1);
                    if (REPEAT_MASK[i] && pressed[i]) begin
                        press_d[i] = rep_fire[i];
                        rep_d[i]   = rep_nxt[i];
                        phase_d[i] = rep_ph[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            phase_q       <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= '0;
                rep_q[i] <= '0;
            end
        end else begin
            pressed       <= pressed_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            phase_q       <= phase_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= cnt_d[i];
                rep_q[i] <= rep_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gpio_button_conditioner.sv
// Bench for gpio_button_conditioner: cycle-level behavioural model plus
// directed scenarios with hand-computed latencies and repeat intervals.
module tb_gpio_button_conditioner;

    localparam int CH     = 5;
    localparam int SYNC   = 2;
    localparam int TDIV   = 4;
    localparam int STABLE = 3;
    localparam int DELAY  = 5;
    localparam int RATE   = 2;
    localparam logic [CH-1:0] MASK = 5'b11000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] pressed;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic          tick;

    gpio_button_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .TICK_DIV(TDIV), .STABLE_TICKS(STABLE),
        .ACTIVE_LOW(1), .REPEAT_MASK(MASK), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .btn_in(btn_in),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .tick(tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pad delay line, tick phase, run-length debounce,
    // and repeats derived from the number of ticks held since acceptance.
    logic [CH-1:0] m_sync [SYNC];
    logic [CH-1:0] m_pressed, m_pp, m_rp;
    bit            m_tick;
    int            m_phase;
    int            m_run  [CH];
    int            m_held [CH];

    task automatic model_clear();
        m_pressed = '0; m_pp = '0; m_rp = '0; m_tick = 1'b0; m_phase = 0;
        for (int i = 0; i < CH; i++) begin m_run[i] = 0; m_held[i] = 0; end
    endtask

    task automatic model_step();
        logic [CH-1:0] raw;
        bit old, acc;
        raw = m_sync[SYNC-1] ^ 5'b11111;
        if (!enable) begin
            model_clear();
        end else begin
            m_pp = '0; m_rp = '0;
            if (m_tick) begin
                for (int i = 0; i < CH; i++) begin
                    old = m_pressed[i];
                    acc = 1'b0;
                    if (raw[i] != old) begin
                        m_run[i]++;
                        if (m_run[i] == STABLE) begin
                            acc = 1'b1;
                            m_pressed[i] = raw[i];
                            m_run[i] = 0;
                            m_held[i] = 0;
                            if (raw[i]) m_pp[i] = 1'b1; else m_rp[i] = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    if (!acc && old && MASK[i]) begin
                        m_held[i]++;
                        if (m_held[i] == DELAY ||
                            (m_held[i] > DELAY && (m_held[i] - DELAY) % RATE == 0))
                            m_pp[i] = 1'b1;
                    end
                end
            end
            m_phase = (m_phase + 1) % TDIV;
            m_tick  = (m_phase == TDIV - 1);
        end
        for (int s = SYNC - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
        m_sync[0] = btn_in;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_clear();
                for (int s = 0; s < SYNC; s++) m_sync[s] = '1;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_pressed", 32'(pressed), 32'(m_pressed));
                check("model_press_pulse", 32'(press_pulse), 32'(m_pp));
                check("model_release_pulse", 32'(release_pulse), 32'(m_rp));
                check("model_tick", 32'(tick), 32'(m_tick));
            end
        end
    end

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic align_tick();
        int k;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tick) break;
        end
        check("align_tick_found", 32'(k < 10), 32'd1);
    endtask

    // Negedges until (signal & m) == want, limit+1 on timeout
    task automatic count_until(input int sel, input logic [CH-1:0] m,
                               input logic [CH-1:0] want, input int limit, output int n);
        logic [CH-1:0] v;
        n = limit + 1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            v = (sel == 0) ? pressed : press_pulse;
            if ((v & m) == want) begin n = k; break; end
        end
    endtask

    int n, ticks, pulses;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        btn_in  = 5'b11111;
        wait_neg(3);
        check("reset_pressed", 32'(pressed), 32'd0);
        check("reset_pulses", 32'({press_pulse, release_pulse}), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Idle: one tick per TDIV cycles, no pulses
        ticks = 0; pulses = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ticks  += int'(tick);
            pulses += (press_pulse != 0 || release_pulse != 0) ? 1 : 0;
        end
        check("idle_tick_count", 32'(ticks), 32'd50);
        check("idle_pulses", 32'(pulses), 32'd0);

        // Clean press and release on ch0
        align_tick();
        btn_in[0] = 1'b0;
        count_until(0, 5'b00001, 5'b00001, 40, n);
        check("press_latency", 32'(n), 32'd13);
        check("press_pulse_ch0", 32'(press_pulse), 32'h01);
        @(negedge clk);
        check("press_pulse_single", 32'(press_pulse), 32'h00);
        align_tick();
        btn_in[0] = 1'b1;
        count_until(0, 5'b00001, 5'b00000, 40, n);
        check("release_latency", 32'(n), 32'd13);
        check("release_pulse_ch0", 32'(release_pulse), 32'h01);

        // Glitch on ch1 spanning two ticks
        align_tick();
        btn_in[1] = 1'b0;
        wait_neg(8);
        btn_in[1] = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            pulses += int'(pressed[1] | press_pulse[1] | release_pulse[1]);
        end
        check("glitch_rejected", 32'(pulses), 32'd0);

        // Auto-repeat on ch3, single press on ch0
        align_tick();
        btn_in = 5'b10110;
        count_until(1, 5'b01000, 5'b01000, 40, n);
        check("repeat_accept_latency", 32'(n), 32'd13);
        check("repeat_accept_both", 32'(press_pulse), 32'h09);
        pulses = 0;
        for (int r = 0; r < 3; r++) begin
            int cnt;
            cnt = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                pulses += int'(press_pulse[0]);
                if (press_pulse[3]) begin cnt = k; break; end
            end
            check($sformatf("repeat_interval_%0d", r), 32'(cnt), (r == 0) ? 32'd20 : 32'd8);
        end
        check("ch0_no_repeat", 32'(pulses), 32'd0);
        btn_in = 5'b11111;
        wait_neg(20);
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            pulses += int'(press_pulse[3]);
        end
        check("repeat_stops", 32'(pulses), 32'd0);

        // Enable gating with ch2 held
        btn_in[2] = 1'b0;
        count_until(0, 5'b00100, 5'b00100, 40, n);
        check("ch2_pressed", 32'(n <= 40), 32'd1);
        wait_neg(2);
        enable = 1'b0;
        @(negedge clk);
        check("disable_pressed", 32'(pressed), 32'd0);
        check("disable_no_release", 32'(release_pulse), 32'd0);
        check("disable_tick", 32'(tick), 32'd0);
        wait_neg(5);
        enable = 1'b1;
        count_until(1, 5'b00100, 5'b00100, 40, n);
        check("reenable_press_latency", 32'(n), 32'd12);
        btn_in = 5'b11111;
        wait_neg(40);

        // Simultaneous press then async reset mid-cycle
        align_tick();
        btn_in = 5'b01110;
        count_until(1, 5'b11111, 5'b10001, 40, n);
        check("simul_latency", 32'(n), 32'd13);
        check("simul_pulses", 32'(press_pulse), 32'h11);
        wait_neg(3);
        check("simul_pressed", 32'(pressed), 32'h11);
        #2 reset_n = 1'b0;
        #1;
        check("async_pressed", 32'(pressed), 32'd0);
        check("async_pulses", 32'({press_pulse, release_pulse}), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        wait_neg(3);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_button_conditioner.md
Name: gpio_button_conditioner

Overview:
Parametrised multi-channel input conditioner for the game's pad-driven controls (reset, pause, new-game, up, down). It replaces ad-hoc per-signal handling in the Caravel wrapper. Per channel it provides:
- synchronisation of asynchronous GPIO pad inputs;
- polarity normalisation and tick-based debouncing;
- press/release strobes and optional auto-repeat.

An `enable` input holds all outputs inactive until the GPIO configuration is loaded, because pad values are indeterminate before that point.

Parameters:
- CHANNELS, 5, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flop depth per channel (legal range >=2).
- TICK_DIV, 250, clk cycles per debounce sample tick (legal range >=2).
- STABLE_TICKS, 4, consecutive ticks a changed level must persist before acceptance (legal range 1..15).
- ACTIVE_LOW, 1, 1 = pad level 0 means pressed; 0 = pad level 1 means pressed.
- REPEAT_MASK, 5'b11000, per-channel auto-repeat enable (default: up/down keys on bits 3,4).
- REPEAT_DELAY, 60, ticks from press acceptance to first repeat strobe (legal range >=1).
- REPEAT_RATE, 10, ticks between subsequent repeat strobes (legal range >=1).

Ports:
- clk, input, 1, design clock.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, GPIO-configured qualifier; low = synchronous clear of conditioning state.
- btn_in, input, CHANNELS, raw pad levels (asynchronous).
- pressed, output, CHANNELS, debounced level, 1 = pressed (polarity normalised).
- press_pulse, output, CHANNELS, one-cycle strobe on accepted press and on each auto-repeat.
- release_pulse, output, CHANNELS, one-cycle strobe on accepted release.
- tick, output, 1, one-cycle sample strobe (exported for debug/bench alignment).

Behaviour:
- Reset (async, reset_n=0):
  - pressed=0, press_pulse=0, release_pulse=0, tick=0.
  - Tick counter=0; all debounce and repeat counters=0.
  - Synchroniser flops load the released pad level (ACTIVE_LOW ? 1 : 0).
- Synchroniser:
  - Free-running, not gated by enable.
  - raw[i] = sync_out[i] XOR ACTIVE_LOW, so raw=1 means pressed.
- Tick generator:
  - Counter runs 0..TICK_DIV-1.
  - tick=1 for exactly the cycle in which the counter equals TICK_DIV-1; the counter then wraps to 0.
  - While enable=0, the counter is held at 0 and tick=0.
- Debounce, per channel i, evaluated only on cycles with tick=1:
  - If raw[i]==pressed[i]: cnt[i]<=0.
  - Otherwise: cnt[i]<=cnt[i]+1.
  - When cnt[i]+1==STABLE_TICKS: pressed[i]<=raw[i], cnt[i]<=0, and the matching press_pulse[i] or release_pulse[i] is asserted.
  - A glitch that returns to the accepted level before acceptance resets cnt[i]; no pulse and no level change result.
  - Latency from pad edge to pressed edge: SYNC_STAGES cycles, then the STABLE_TICKS-th tick at or after the synchroniser output changes.
- Pulse timing:
  - press_pulse and release_pulse are registered.
  - A pulse is high for exactly the one cycle following the tick edge, i.e. the same cycle in which pressed first shows its new value.
  - Pulses are 0 on all other cycles.
- Auto-repeat (channels with REPEAT_MASK[i]=1):
  - rep[i] loads 0 on press acceptance.
  - On each subsequent tick while pressed[i]=1, rep[i] increments.
  - First repeat strobe when REPEAT_DELAY ticks have elapsed since acceptance.
  - Further strobes every REPEAT_RATE ticks thereafter.
  - rep[i] is cleared on release.
  - A repeat strobe is a press_pulse[i] cycle, timed exactly like an acceptance pulse.
  - rep counter width is clog2(max(REPEAT_DELAY,REPEAT_RATE)+1); it reloads and never overflows.
  - Masked-off channels produce exactly one press_pulse per press.
- Simultaneous events:
  - Channels are fully independent; any subset may pulse in the same cycle.
  - Acceptance and repeat on the same channel cannot coincide, because repeat requires pressed=1 beforehand.
- enable=0 (synchronous clear):
  - Next edge: pressed=0, pulses=0, all cnt/rep counters=0.
  - No release_pulse is generated for channels that were pressed.
- enable 0->1 with a button already held: treated as a new press; press_pulse is asserted after STABLE_TICKS ticks.
- Reset asserted mid-debounce or mid-repeat: outputs clear immediately without a clock edge.

Test Plan:
1. Reset, idle, enable=1, btn_in=5'b11111 (TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2) -> all outputs 0; tick high 1 cycle in every 4; no pulses over 200 cycles.
2. Clean press/release: btn_in[0]=0 held -> pressed[0] rises on the 3rd tick after the 2-cycle sync delay, with press_pulse[0] high in that same single cycle. Then btn_in[0]=1 -> pressed[0] falls after 3 ticks with one release_pulse[0].
3. Glitch rejection: btn_in[1]=0 for 2 ticks, then 1 -> pressed[1] stays 0; press_pulse and release_pulse stay 0.
4. Auto-repeat (REPEAT_DELAY=5, REPEAT_RATE=2): hold ch3 and ch0 -> press_pulse[3] at acceptance tick A, then at A+5, A+7, A+9...; press_pulse[0] once only. Releasing ch3 stops repeats.
5. Enable gating: ch2 pressed, enable=0 -> pressed[2]=0 next cycle, no release_pulse, tick=0. With ch2 still held, enable=1 -> press_pulse[2] after 3 ticks.
6. Async reset and simultaneity: press ch0 and ch4 on the same cycle -> both press_pulses in the same cycle. Assert reset_n=0 mid-count between clock edges -> all outputs 0 immediately.
